// File: rtl/s_mem_init_fsm_if.sv
// Bus between the control FSM (master) and the RAM-init engine (slave).
//   start/abort/mode/fill_value : pass request and pattern operands (master -> slave)
//   busy/finish                 : pass status (slave -> master)
//   wren/address/data           : RAM write port (slave -> RAM)
interface s_mem_init_fsm_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              finish;
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;

  modport master (output start, abort, mode, fill_value,
                  input  busy, finish, wren, address, data);
  modport slave  (input  start, abort, mode, fill_value,
                  output busy, finish, wren, address, data);
endinterface

// File: rtl/s_mem_init_fsm.sv
// RAM fill engine: on start, writes DEPTH locations (0..DEPTH-1) with one of
// four patterns, holding each address/data pair for HOLD_CYCLES clocks, then
// pulses finish for one cycle.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : s_mem_init_fsm_if slave (request in, status + RAM write port out)
// Patterns (mode captured on start): 0 addr, 1 fill_value,
// 2 DEPTH-1-addr, 3 addr ^ fill_value.
module s_mem_init_fsm #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  s_mem_init_fsm_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]        mode;
    logic [DATA_W-1:0] value;
  } cfg_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  cfg_t              cfg_q, cfg_d;
  logic [DATA_W-1:0] pat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      cfg_q   <= cfg_d;
    end
  end

  // Pattern from captured config; the address never exceeds DEPTH-1, so the
  // descending value fits ADDR_W bits before the cast to DATA_W.
  always_comb begin
    pat = '0;
    unique case (cfg_q.mode)
      2'd0: pat = DATA_W'(addr_q);
      2'd1: pat = cfg_q.value;
      2'd2: pat = DATA_W'(LAST_ADDR - addr_q);
      2'd3: pat = DATA_W'(addr_q) ^ cfg_q.value;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    cfg_d       = cfg_q;
    bus.busy    = 1'b0;
    bus.finish  = 1'b0;
    bus.wren    = 1'b0;
    bus.address = '0;
    bus.data    = '0;
    unique case (state_q)
      S_IDLE: begin
        // start beats a simultaneous abort: abort is only looked at in WRITE
        if (bus.start) begin
          cfg_d   = '{mode: bus.mode, value: bus.fill_value};
          addr_d  = '0;
          hold_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.busy    = 1'b1;
        bus.wren    = 1'b1;
        bus.address = addr_q;
        bus.data    = pat;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (hold_q == LAST_HOLD) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        bus.busy   = 1'b1;
        bus.finish = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
